rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes on every input and the output.
- Selects among requesting inputs itself, by round-robin or fixed priority; no external sel.
- One registered output stage. Reports which input the held word came from.
- Sits in the datapath wherever several producers share one consumer, e.g. result/writeback source selection.

Parameters:
- N_IN, 4, number of input channels (2..16; need not be a power of two).
- WIDTH, 32, data width in bits.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).
- SEL_W, $clog2(N_IN), width of the source index (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready (one-hot or zero).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0, so channel 0 has highest priority first.
  - in_ready is all zeros while rst_n=0.
- Load enable: load = !out_valid | out_ready. The output stage may take a new word when empty, or when the held word is drained in the same cycle.
- Grant (combinational):
  - Only when load=1 and at least one in_valid is set.
  - RR_MODE=1: first valid channel searching ptr, ptr+1, ..., wrapping from N_IN-1 to 0.
  - RR_MODE=0: lowest-index valid channel.
  - in_ready = one-hot grant. All zeros if load=0 or no channel is valid.
  - in_ready never depends on in_data. It may depend on in_valid and out_ready.
- Transfer on rising edge when load=1 and a grant exists:
  - out_data <= selected channel's data.
  - out_sel <= granted index g.
  - out_valid <= 1.
  - RR_MODE=1 only: ptr <= (g==N_IN-1) ? 0 : g+1.
- Drain without refill (out_ready=1, out_valid=1, no valid input): out_valid <= 0. out_data and out_sel hold their last value.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_sel and out_valid are held stable.
  - in_ready = 0.
  - ptr unchanged.
- Throughput and latency:
  - Back-to-back, one word per cycle when out_ready stays high.
  - Latency from input handshake to out_valid is 1 cycle.
- No request: ptr unchanged. Idle cycles do not rotate priority.
- Fairness (RR_MODE=1): with all N_IN channels continuously valid and the output never stalled, grants go 0,1,...,N_IN-1,0,... Each channel waits at most N_IN-1 transfers.
- Non-power-of-two N_IN: ptr and out_sel never exceed N_IN-1. in_valid bits are only defined for indices below N_IN.
- Reset mid-operation: any held word is discarded immediately (out_valid=0, asynchronously). No in_ready is asserted during reset, so no input transfer is lost silently.
- Simultaneous drain and refill in one cycle: the new word replaces the old one with no bubble, and out_valid stays 1.

Decomposition:
- Shared package: no typedefs needed. Constants are RR_MODE encodings (ARB_FIXED=0, ARB_RR=1) and a clog2 helper if the toolflow lacks $clog2.
- One sub-module: rr_arbiter (parameters N_IN, RR_MODE).
  - Inputs: req[N_IN], en, ptr.
  - Outputs: one-hot gnt, encoded gnt_idx.
  - Purely combinational. The top level owns ptr and the output register.

Test Plan:
- Reset: assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0, out_data=0, out_sel=0 and in_ready=0 immediately (asynchronous). After release, the first grant with all channels valid goes to ch0.
- Round-robin rotation: N_IN=4, RR_MODE=1, all in_valid=4'b1111, in_data[i]=32'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data 32'hA0, A1, A2, A3, A0 on consecutive cycles.
- Skip and wrap: ptr=3, in_valid=4'b0101 -> grant ch0 (in_ready=4'b0001), then ptr=1. Next cycle grants ch2, then ptr=3.
- Stall: out_valid=1 holding 32'hDEADBEEF, out_ready=0 for 5 cycles with all inputs valid -> out_data/out_sel stable, in_ready=0, ptr unchanged. First out_ready=1 cycle loads the next word with no bubble.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held -> every transfer takes ch1. ch3 is only served after in_valid[1] drops.
- Odd width/count: N_IN=3, WIDTH=8, all valid -> out_sel 0,1,2,0; never 3. Idle cycles with in_valid=0 leave ptr unchanged (next grant continues the sequence).

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and small index helpers for the round-robin stream mux.
package rr_stream_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Channel visited at step k of a search that starts at base and wraps at n.
  function automatic int chan_at(input int base, input int k, input int n);
    return (base + k >= n) ? (base + k - n) : (base + k);
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or lowest index first.
// No state; the caller owns the pointer and decides when it advances.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int RR_MODE = ARB_RR,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic             en,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] w_base;
  logic [SEL_W-1:0] w_c;

  assign w_base = (RR_MODE == ARB_RR) ? ptr : '0;

  // The first hit wins; later hits are masked because gnt is already non-zero.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_c     = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_c = SEL_W'(chan_at(int'(w_base), k, N_IN));
      if (en && (gnt == '0) && req[w_c]) begin
        gnt[w_c] = 1'b1;
        gnt_idx  = w_c;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-input valid/ready stream mux with one registered output stage; 1-cycle latency.
// Inputs are granted only when the stage is empty or draining, so a stall holds everything.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 32,
  parameter int RR_MODE = ARB_RR,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic             w_load;
  logic             w_en;
  logic             w_gnt_vld;
  logic [N_IN-1:0]  w_gnt;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_ch_data [N_IN];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;

  for (genvar i = 0; i < N_IN; i++) begin : g_unpack
    assign w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign w_load = !r_out_valid || out_ready;
  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_en   = w_load && rst_n;

  rr_arbiter #(
    .N_IN    (N_IN),
    .RR_MODE (RR_MODE),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .en      (w_en),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_gnt_vld  = |w_gnt;
  assign w_sel_data = w_ch_data[w_gnt_idx];
  assign w_ptr_nxt  = SEL_W'(wrap_inc(int'(w_gnt_idx), N_IN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gnt_idx;
        if (RR_MODE == ARB_RR) begin
          r_ptr <= w_ptr_nxt;
        end
      end else begin
        // Drain with nothing to refill: data and source index keep their last value.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: vector table, corner-case sequences, and random traffic vs a queue-free model.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Two 4x32 instances (round-robin and fixed priority) share their inputs.
  logic [127:0] in_data4;
  logic [3:0]   in_valid4;
  logic         out_ready4;
  logic [3:0]   rdy_rr, rdy_fx;
  logic [31:0]  od_rr, od_fx;
  logic         ov_rr, ov_fx;
  logic [1:0]   os_rr, os_fx;

  logic [23:0]  in_data3;
  logic [2:0]   in_valid3, rdy_3;
  logic         out_ready3;
  logic [7:0]   od_3;
  logic         ov_3;
  logic [1:0]   os_3;

  rr_stream_mux #(.N_IN(4), .WIDTH(32), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(rdy_rr),
    .out_data(od_rr), .out_valid(ov_rr), .out_ready(out_ready4), .out_sel(os_rr));

  rr_stream_mux #(.N_IN(4), .WIDTH(32), .RR_MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(rdy_fx),
    .out_data(od_fx), .out_valid(ov_fx), .out_ready(out_ready4), .out_sel(os_fx));

  rr_stream_mux #(.N_IN(3), .WIDTH(8), .RR_MODE(1)) u_3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(rdy_3),
    .out_data(od_3), .out_valid(ov_3), .out_ready(out_ready3), .out_sel(os_3));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  es;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [15];

  // Reference: search order straight from the arbitration rule, modulo arithmetic.
  function automatic int model_grant(input int n, input bit rr, input int ptr, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      int c;
      c = rr ? (ptr + k) % n : k;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int g);
    return (g < 0) ? 32'd0 : (32'd1 << g);
  endfunction

  int          m_ptr [3];
  bit          m_ov  [3];
  logic [31:0] m_od  [3];
  int          m_os  [3];
  int          g     [3];
  int          n_i;
  bit          rr_i, rd_i, ld_i;
  logic [3:0]  v_i;
  int          exp_seq [4];

  initial begin
    rst_n      = 1'b0;
    in_data4   = '0;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b0;
    in_data3   = '0;
    in_valid3  = '0;
    out_ready3 = 1'b0;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[10] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
    tbl[12] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0};

    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(ov_rr), 32'd0);
    chk("reset_data", od_rr, 32'd0);
    chk("reset_sel", 32'(os_rr), 32'd0);
    chk("reset_ready", 32'(rdy_rr), 32'd0);
    rst_n    = 1'b1;
    in_data4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // Rotation, skip/wrap, drain, idle and stall rows from a fresh reset.
    for (int r = 0; r < 15; r++) begin
      in_valid4  = tbl[r].v;
      out_ready4 = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_ready", r), 32'(rdy_rr), 32'(tbl[r].er));
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), 32'(ov_rr), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_sel", r), 32'(os_rr), 32'(tbl[r].es));
      chk($sformatf("tbl%0d_data", r), od_rr, tbl[r].ed);
    end

    // Stall with a held word, then release with no bubble (ptr should still be 1).
    in_data4[31:0] = 32'hDEADBEEF;
    in_valid4      = 4'b0001;
    out_ready4     = 1'b1;
    #1;
    chk("stall_load_ready", 32'(rdy_rr), 32'h1);
    @(negedge clk);
    chk("stall_load_data", od_rr, 32'hDEADBEEF);
    in_data4[31:0] = 32'hA0;
    in_valid4      = 4'b1111;
    out_ready4     = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_ready", 32'(rdy_rr), 32'h0);
      @(negedge clk);
      chk("stall_data", od_rr, 32'hDEADBEEF);
      chk("stall_sel", 32'(os_rr), 32'd0);
      chk("stall_valid", 32'(ov_rr), 32'd1);
    end
    out_ready4 = 1'b1;
    #1;
    chk("unstall_ready", 32'(rdy_rr), 32'h2);
    @(negedge clk);
    chk("unstall_valid", 32'(ov_rr), 32'd1);
    chk("unstall_sel", 32'(os_rr), 32'd1);
    chk("unstall_data", od_rr, 32'hA1);

    // Asynchronous reset while a word is held.
    out_ready4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov_rr), 32'd0);
    chk("midrst_data", od_rr, 32'd0);
    chk("midrst_sel", 32'(os_rr), 32'd0);
    chk("midrst_ready_rr", 32'(rdy_rr), 32'd0);
    chk("midrst_ready_fx", 32'(rdy_fx), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    out_ready4 = 1'b1;
    #1;
    chk("postrst_ready", 32'(rdy_rr), 32'h1);
    @(negedge clk);
    chk("postrst_sel", 32'(os_rr), 32'd0);
    chk("postrst_data", od_rr, 32'hA0);

    // Fixed priority: ch1 starves ch3 until it drops.
    in_valid4 = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("fixed_ready", 32'(rdy_fx), 32'h2);
      @(negedge clk);
      chk("fixed_sel", 32'(os_fx), 32'd1);
      chk("fixed_data", od_fx, 32'hA1);
    end
    in_valid4 = 4'b1000;
    #1;
    chk("fixed_ch3_ready", 32'(rdy_fx), 32'h8);
    @(negedge clk);
    chk("fixed_ch3_sel", 32'(os_fx), 32'd3);
    chk("fixed_ch3_data", od_fx, 32'hA3);

    // Three channels: wraps 2 -> 0, and idle cycles leave the pointer alone.
    in_data3   = {8'h12, 8'h11, 8'h10};
    out_ready3 = 1'b1;
    exp_seq    = '{0, 1, 2, 0};
    for (int s = 0; s < 4; s++) begin
      in_valid3 = 3'b111;
      #1;
      chk("odd_ready", 32'(rdy_3), onehot(exp_seq[s]));
      @(negedge clk);
      chk("odd_sel", 32'(os_3), 32'(exp_seq[s]));
      chk("odd_data", 32'(od_3), 32'h10 + 32'(exp_seq[s]));
    end
    in_valid3 = 3'b000;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("odd_idle_ready", 32'(rdy_3), 32'd0);
      @(negedge clk);
      chk("odd_idle_valid", 32'(ov_3), 32'd0);
    end
    in_valid3 = 3'b111;
    #1;
    chk("odd_resume_ready", 32'(rdy_3), 32'h2);
    @(negedge clk);
    chk("odd_resume_sel", 32'(os_3), 32'd1);

    // Random traffic on all three instances against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_os[i] = 0;
    end
    for (int t = 0; t < 400; t++) begin
      in_valid4  = 4'($urandom);
      in_data4   = {$urandom, $urandom, $urandom, $urandom};
      out_ready4 = ($urandom_range(3) != 0);
      in_valid3  = 3'($urandom);
      in_data3   = 24'($urandom);
      out_ready3 = ($urandom_range(3) != 0);
      for (int i = 0; i < 3; i++) begin
        n_i  = (i == 2) ? 3 : 4;
        rr_i = (i != 1);
        v_i  = (i == 2) ? {1'b0, in_valid3} : in_valid4;
        rd_i = (i == 2) ? out_ready3 : out_ready4;
        ld_i = !m_ov[i] || rd_i;
        g[i] = ld_i ? model_grant(n_i, rr_i, m_ptr[i], v_i) : -1;
        if (ld_i) begin
          if (g[i] >= 0) begin
            m_ov[i] = 1'b1;
            m_os[i] = g[i];
            m_od[i] = (i == 2) ? 32'(8'(in_data3 >> (g[i] * 8))) : 32'(in_data4 >> (g[i] * 32));
            if (rr_i) m_ptr[i] = (g[i] + 1) % n_i;
          end else begin
            m_ov[i] = 1'b0;
          end
        end
      end
      #1;
      chk("rand_rr_ready", 32'(rdy_rr), onehot(g[0]));
      chk("rand_fx_ready", 32'(rdy_fx), onehot(g[1]));
      chk("rand_3_ready", 32'(rdy_3), onehot(g[2]));
      @(negedge clk);
      chk("rand_rr_valid", 32'(ov_rr), 32'(m_ov[0]));
      chk("rand_rr_sel", 32'(os_rr), 32'(m_os[0]));
      chk("rand_rr_data", od_rr, m_od[0]);
      chk("rand_fx_valid", 32'(ov_fx), 32'(m_ov[1]));
      chk("rand_fx_sel", 32'(os_fx), 32'(m_os[1]));
      chk("rand_fx_data", od_fx, m_od[1]);
      chk("rand_3_valid", 32'(ov_3), 32'(m_ov[2]));
      chk("rand_3_sel", 32'(os_3), 32'(m_os[2]));
      chk("rand_3_data", 32'(od_3), m_od[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
